seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 13 +
 rtl/tick_gen.sv | 18 +
 rtl/seg_scan_ctrl.sv | 78 +++++++
 tb/tb_seg_scan_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and display-record type for the segment scan controller
package seg_pkg;
  localparam int NDIG = 8;
  localparam int SCAN_W = 3;
  localparam int SCAN_DIV_DEF = 100000;
  localparam logic [NDIG-1:0] LES_RST = 8'hFF;
  typedef struct packed {
    logic [4*NDIG-1:0] hexs;
    logic [NDIG-1:0]   point;
    logic [NDIG-1:0]   les;
  } disp_t;
  localparam disp_t DISP_RST = '{hexs: '0, point: '0, les: LES_RST};
endpackage

// File: rtl/tick_gen.sv
// tick_gen: enable-gated prescaler emitting one tick every DIV enabled cycles
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick  = en && cnt_q == W'(DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + W'(en);
  // prescaler count, frozen while en is low
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit scan with frame-synchronous shadow update; SEG_BLINK_EN adds blink overlay
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic                load,
  input  logic [4*NDIG-1:0]   hexs_in,
  input  logic [NDIG-1:0]     point_in,
  input  logic [NDIG-1:0]     les_in,
  input  logic [NDIG-1:0]     blink_mask,
  output logic [SCAN_W-1:0]   Scan,
  output logic [4*NDIG-1:0]   Hexs,
  output logic [NDIG-1:0]     point,
  output logic [NDIG-1:0]     LES,
  output logic                busy,
  output logic                load_ack,
  output logic                frame_done
);
  logic tick, frame_end;
  logic [SCAN_W-1:0] scan_q;
  disp_t stage_q, shadow_q;
  logic busy_q, ack_q, fd_q;

  tick_gen #(.DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .en(scan_en), .tick(tick));

  assign frame_end = tick && scan_q == SCAN_W'(NDIG - 1);

  // digit stepping, staging capture and commit to shadows only at frame boundaries
  always_ff @(posedge clk)
    if (rst) begin
      scan_q   <= '0;
      stage_q  <= '0;
      shadow_q <= DISP_RST;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      scan_q <= scan_q + SCAN_W'(tick);
      if (load) stage_q <= '{hexs: hexs_in, point: point_in, les: les_in};
      if (frame_end && busy_q) shadow_q <= stage_q;
      busy_q <= load || (busy_q && !frame_end);
      ack_q  <= frame_end && busy_q;
      fd_q   <= frame_end;
    end

  assign Scan       = scan_q;
  assign Hexs       = shadow_q.hexs;
  assign point      = shadow_q.point;
  assign busy       = busy_q;
  assign load_ack   = ack_q;
  assign frame_done = fd_q;

`ifdef SEG_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] bcnt_q;
  logic phase_q, bwrap;
  assign bwrap = bcnt_q == BW'(BLINK_FRAMES - 1);
  // frame counter flipping the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk)
    if (rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (frame_end) begin
      bcnt_q  <= bwrap ? '0 : bcnt_q + BW'(1);
      phase_q <= phase_q ^ bwrap;
    end
  assign LES = shadow_q.les | ({NDIG{phase_q}} & blink_mask);
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign LES = shadow_q.les;
`endif
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table vectors, corner sequences and random traffic against a frame-level model
module tb_seg_scan_ctrl;
  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam int FRAME = DIV * 8;

  logic clk = 1'b0;
  logic rst, scan_en, load;
  logic [31:0] hexs_in;
  logic [7:0] point_in, les_in, blink_mask;
  logic [2:0] Scan;
  logic [31:0] Hexs;
  logic [7:0] point, LES;
  logic busy, load_ack, frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .load(load),
    .hexs_in(hexs_in), .point_in(point_in), .les_in(les_in), .blink_mask(blink_mask),
    .Scan(Scan), .Hexs(Hexs), .point(point), .LES(LES),
    .busy(busy), .load_ack(load_ack), .frame_done(frame_done)
  );

  int vecs = 0;
  int errs = 0;

  // reference model: time measured in enabled cycles, frames counted directly
  int en_cnt, frames;
  logic [31:0] m_hex, s_hex;
  logic [7:0] m_pt, s_pt, m_les, s_les;
  logic m_busy, m_ack, m_fd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic fe;
    if (rst) begin
      en_cnt = 0; frames = 0;
      m_hex = 0; m_pt = 0; m_les = 8'hFF;
      s_hex = 0; s_pt = 0; s_les = 0;
      m_busy = 0; m_ack = 0; m_fd = 0;
    end else begin
      fe = scan_en && (en_cnt % FRAME == FRAME - 1);
      m_fd = fe;
      m_ack = fe && m_busy;
      if (fe && m_busy) begin m_hex = s_hex; m_pt = s_pt; m_les = s_les; end
      if (fe) frames++;
      if (load) begin s_hex = hexs_in; s_pt = point_in; s_les = les_in; end
      m_busy = load || (m_busy && !fe);
      if (scan_en) en_cnt++;
    end
  endtask

  function automatic logic [7:0] exp_les();
`ifdef SEG_BLINK_EN
    return m_les | ({8{((frames / BF) % 2) == 1}} & blink_mask);
`else
    return m_les;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("scan", 32'(Scan), 32'((en_cnt / DIV) % 8));
    chk("hexs", Hexs, m_hex);
    chk("point", 32'(point), 32'(m_pt));
    chk("les", 32'(LES), 32'(exp_les()));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("load_ack", 32'(load_ack), 32'(m_ack));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic do_load(input logic [31:0] h);
    hexs_in = h; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(); n++;
      if (load_ack) return;
    end
    chk("ack_timeout", 32'(load_ack), 32'd1);
  endtask

  task automatic to_frame_end();
    for (int i = 0; i < 2 * FRAME && en_cnt % FRAME != FRAME - 1; i++) step();
  endtask

  typedef struct {
    logic r, en, ld;
    logic [31:0] hx;
    int n;
    logic [2:0] e_scan;
    logic [31:0] e_hex;
    logic [7:0] e_les;
    logic e_busy, e_ack, e_fd;
  } vec_t;

  vec_t tbl[6];
  int n;

  initial begin
    rst = 1; scan_en = 0; load = 0; hexs_in = 0; point_in = 0; les_in = 0; blink_mask = 0;
    tbl[0] = '{1, 0, 0, 32'h0,        1,  3'd0, 32'h0,        8'hFF, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 32'h0,        9,  3'd2, 32'h0,        8'hFF, 0, 0, 0};
    tbl[2] = '{0, 1, 1, 32'h12345678, 1,  3'd2, 32'h0,        8'hFF, 1, 0, 0};
    tbl[3] = '{0, 1, 0, 32'h0,        21, 3'd7, 32'h0,        8'hFF, 1, 0, 0};
    tbl[4] = '{0, 1, 0, 32'h0,        1,  3'd0, 32'h12345678, 8'h00, 0, 1, 1};
    tbl[5] = '{0, 1, 0, 32'h0,        1,  3'd0, 32'h12345678, 8'h00, 0, 0, 0};
    foreach (tbl[k]) begin
      rst = tbl[k].r; scan_en = tbl[k].en; load = tbl[k].ld; hexs_in = tbl[k].hx;
      for (int c = 0; c < tbl[k].n; c++) begin
        step();
        load = 1'b0; rst = 1'b0;
      end
      chk($sformatf("tbl%0d_scan", k), 32'(Scan), 32'(tbl[k].e_scan));
      chk($sformatf("tbl%0d_hexs", k), Hexs, tbl[k].e_hex);
      chk($sformatf("tbl%0d_les", k), 32'(LES), 32'(tbl[k].e_les));
      chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_ack", k), 32'(load_ack), 32'(tbl[k].e_ack));
      chk($sformatf("tbl%0d_fd", k), 32'(frame_done), 32'(tbl[k].e_fd));
    end

    // last write wins within one frame
    do_load(32'hAAAA0000);
    for (int i = 0; i < 5; i++) step();
    do_load(32'h0000BBBB);
    wait_ack(n);
    chk("last_write_hexs", Hexs, 32'h0000BBBB);

    // load exactly on frame_end with nothing pending: commit a full frame later
    to_frame_end();
    do_load(32'hCAFEF00D);
    chk("fe_load_busy", 32'(busy), 32'd1);
    chk("fe_load_noack", 32'(load_ack), 32'd0);
    chk("fe_load_hold", Hexs, 32'h0000BBBB);
    wait_ack(n);
    chk("fe_load_delay", 32'(n), 32'(FRAME));
    chk("fe_load_hexs", Hexs, 32'hCAFEF00D);

    // scan_en low at Scan=5 mid-count: hold, then resume from the same count
    for (int i = 0; i < 2 * FRAME && !((en_cnt / DIV) % 8 == 5 && en_cnt % DIV == 1); i++) step();
    scan_en = 0;
    for (int i = 0; i < 10; i++) step();
    chk("hold_scan", 32'(Scan), 32'd5);
    scan_en = 1;
    n = 0;
    for (int i = 0; i < 10 && Scan == 3'd5; i++) begin step(); n++; end
    chk("resume_steps", 32'(n), 32'd3);

    // load on frame_end while busy: old commits, new stays staged
    do_load(32'h11111111);
    to_frame_end();
    do_load(32'h22222222);
    chk("fe_busy_hexs", Hexs, 32'h11111111);
    chk("fe_busy_ack", 32'(load_ack), 32'd1);
    chk("fe_busy_busy", 32'(busy), 32'd1);
    wait_ack(n);
    chk("fe_busy_next", Hexs, 32'h22222222);

    // reset wins over a coincident load
    rst = 1; load = 1; hexs_in = 32'h55555555;
    step();
    rst = 0; load = 0;
    chk("rst_load_busy", 32'(busy), 32'd0);
    chk("rst_load_hexs", Hexs, 32'd0);
    chk("rst_load_les", 32'(LES), 32'hFF);

    // blink overlay on digit 0 over several frames
    les_in = 8'h00; blink_mask = 8'h01;
    do_load(32'h0);
    for (int i = 0; i < 6 * FRAME; i++) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      scan_en = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 19) == 0);
      hexs_in = $urandom; point_in = 8'($urandom); les_in = 8'($urandom);
      if ($urandom_range(0, 99) == 0) blink_mask = 8'($urandom);
      step();
    end
    rst = 0; load = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
